// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds state encoding, segment patterns and a digit clamp helper.
package countdown_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001101;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;

   function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// One-digit BCD to active-low seven-segment encoder.
// Non-decimal codes and blank both turn every segment off.
module bcd_to_seg
   import countdown_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_i,
   input  logic             blank_i,
   output logic [6:0]       seg_o
);

   // decode one digit, blank overrides everything
   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Multi-digit BCD up/down timer with prescaler, start/pause/expire
// state machine and per-digit seven-segment outputs.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic [BCD_W*DIGITS-1:0]   load_value,
   input  logic                      up_mode,
   input  logic                      start_stop,
   input  logic                      blank,
   output logic [BCD_W*DIGITS-1:0]   count_bcd,
   output logic [7*DIGITS-1:0]       seg,
   output logic                      running,
   output logic                      expired,
   output logic                      done
);

   localparam int CW = BCD_W * DIGITS;
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] target_q, target_d;
   logic          mode_q, mode_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;
   logic [CW-1:0] clamped;
   logic [CW-1:0] stepped;
   logic [CW-1:0] terminal;
   logic          tick;

   // clamp every incoming digit to 9
   always_comb begin
      clamped = '0;
      for (int i = 0; i < DIGITS; i++) begin
         clamped[i*BCD_W +: BCD_W] = clamp_digit(load_value[i*BCD_W +: BCD_W]);
      end
   end

   // ripple BCD increment/decrement; carry doubles as borrow
   always_comb begin
      logic             cy;
      logic [BCD_W-1:0] dig;
      stepped = count_q;
      cy      = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         dig = count_q[i*BCD_W +: BCD_W];
         if (cy) begin
            if (mode_q) begin
               if (dig == 4'd9) begin
                  stepped[i*BCD_W +: BCD_W] = 4'd0;
               end else begin
                  stepped[i*BCD_W +: BCD_W] = dig + 4'd1;
                  cy = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  stepped[i*BCD_W +: BCD_W] = 4'd9;
               end else begin
                  stepped[i*BCD_W +: BCD_W] = dig - 4'd1;
                  cy = 1'b0;
               end
            end
         end
      end
   end

   assign terminal = mode_q ? target_q : '0;
   assign tick     = (state_q == ST_RUN) && (presc_q == PS_MAX);

   // state, count and prescaler registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         target_q <= '0;
         mode_q   <= 1'b0;
         presc_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         target_q <= target_d;
         mode_q   <= mode_d;
         presc_q  <= presc_d;
         done_q   <= done_d;
      end
   end

   // next state: load wins, then start/pause, then ticks
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      target_d = target_q;
      mode_d   = mode_q;
      presc_d  = presc_q;
      if (load) begin
         mode_d  = up_mode;
         presc_d = '0;
         state_d = ST_IDLE;
         if (up_mode) begin
            count_d  = '0;
            target_d = clamped;
         end else begin
            count_d  = clamped;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_stop) begin
                  state_d = (count_q == terminal) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (start_stop) begin
                  state_d = ST_IDLE;
               end
               if (tick) begin
                  count_d = stepped;
                  if (stepped == terminal) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   // outputs decoded from registered state
   always_comb begin
      running   = (state_q == ST_RUN);
      expired   = (state_q == ST_DONE);
      done      = done_q;
      count_bcd = count_q;
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_to_seg u_seg (
         .bcd_i   (count_q[g*BCD_W +: BCD_W]),
         .blank_i (blank),
         .seg_o   (seg[g*7 +: 7])
      );
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with DIGITS=2, TICK_DIV=4.
// Expected count steps are queued on stimulus and popped on each change.
module tb_countdown_timer;

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        load;
   logic [7:0]  load_value;
   logic        up_mode;
   logic        start_stop;
   logic        blank;
   logic [7:0]  count_bcd;
   logic [13:0] seg;
   logic        running;
   logic        expired;
   logic        done;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   localparam logic [13:0] SEG_00  = {7'b0000001, 7'b0000001};
   localparam logic [13:0] SEG_09  = {7'b0000001, 7'b0000100};
   localparam logic [13:0] SEG_OFF = 14'h3FFF;

   countdown_timer #(
      .DIGITS   (2),
      .TICK_DIV (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .up_mode    (up_mode),
      .start_stop (start_stop),
      .blank      (blank),
      .count_bcd  (count_bcd),
      .seg        (seg),
      .running    (running),
      .expired    (expired),
      .done       (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] int2bcd(input int n);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'(n / 10);
      lo = 4'(n % 10);
      return {hi, lo};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v, input logic up);
      load_value = v;
      up_mode    = up;
      load       = 1'b1;
      step();
      load       = 1'b0;
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      step();
      start_stop = 1'b0;
   endtask

   // waits for count_bcd to move; cyc=-1 on timeout
   task automatic wait_change(input int max_cyc, output logic [7:0] v, output int cyc);
      logic [7:0] prev;
      prev = count_bcd;
      v    = prev;
      cyc  = 0;
      while (cyc < max_cyc) begin
         step();
         cyc++;
         if (count_bcd !== prev) begin
            v = count_bcd;
            return;
         end
      end
      cyc = -1;
   endtask

   task automatic drain(input string name);
      exp_t       e;
      logic [7:0] v;
      int         c;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         wait_change(20, v, c);
         checks++;
         if (v !== e.val || c != e.cyc) begin
            errors++;
            $display("FAIL %s: count %h after %0d cycles, expected %h after %0d",
                     name, v, c, e.val, e.cyc);
         end
         if (c < 0) sb.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (count_bcd !== 8'h00 || running !== 1'b0 || expired !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: cnt=%h run=%b exp=%b done=%b, expected 00 0 0 0",
                  count_bcd, running, expired, done);
      end
      checks++;
      if (seg !== SEG_00) begin
         errors++;
         $display("FAIL reset_seg: seg=%b expected %b", seg, SEG_00);
      end
      #2 reset = 1'b0;
      step();
   endtask

   task automatic test_down();
      do_load(8'h12, 1'b0);
      checks++;
      if (count_bcd !== 8'h12 || running !== 1'b0) begin
         errors++;
         $display("FAIL down_load: cnt=%h run=%b expected 12 0", count_bcd, running);
      end
      pulse_ss();
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL down_running: run=%b expected 1", running);
      end
      for (int n = 11; n >= 0; n--) sb.push_back('{int2bcd(n), 4});
      drain("down_step");
      checks++;
      if (done !== 1'b1 || expired !== 1'b1 || running !== 1'b0 || seg !== SEG_00) begin
         errors++;
         $display("FAIL down_expire: done=%b exp=%b run=%b seg=%b expected 1 1 0 %b",
                  done, expired, running, seg, SEG_00);
      end
      step();
      checks++;
      if (done !== 1'b0 || expired !== 1'b1 || count_bcd !== 8'h00) begin
         errors++;
         $display("FAIL down_done_pulse: done=%b exp=%b cnt=%h expected 0 1 00",
                  done, expired, count_bcd);
      end
   endtask

   task automatic test_borrow();
      do_load(8'h10, 1'b0);
      pulse_ss();
      sb.push_back('{8'h09, 4});
      drain("borrow_step");
      checks++;
      if (seg !== SEG_09) begin
         errors++;
         $display("FAIL borrow_seg: seg=%b expected %b", seg, SEG_09);
      end
   endtask

   task automatic test_pause();
      do_load(8'h50, 1'b0);
      pulse_ss();
      step();
      pulse_ss();
      checks++;
      if (running !== 1'b0 || expired !== 1'b0) begin
         errors++;
         $display("FAIL pause_state: run=%b exp=%b expected 0 0", running, expired);
      end
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (count_bcd !== 8'h50) begin
         errors++;
         $display("FAIL pause_hold: cnt=%h expected 50", count_bcd);
      end
      pulse_ss();
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL resume_state: run=%b expected 1", running);
      end
      sb.push_back('{8'h49, 2});
      sb.push_back('{8'h48, 4});
      drain("resume_step");
   endtask

   task automatic test_up();
      do_load(8'h03, 1'b1);
      checks++;
      if (count_bcd !== 8'h00) begin
         errors++;
         $display("FAIL up_load: cnt=%h expected 00", count_bcd);
      end
      pulse_ss();
      for (int n = 1; n <= 3; n++) sb.push_back('{int2bcd(n), 4});
      drain("up_step");
      checks++;
      if (done !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("FAIL up_expire: done=%b exp=%b run=%b expected 1 1 0",
                  done, expired, running);
      end
      pulse_ss();
      step();
      checks++;
      if (expired !== 1'b1 || running !== 1'b0 || count_bcd !== 8'h03 || done !== 1'b0) begin
         errors++;
         $display("FAIL up_ignore_ss: exp=%b run=%b cnt=%h done=%b expected 1 0 03 0",
                  expired, running, count_bcd, done);
      end
   endtask

   task automatic test_clamp_priority();
      load_value = 8'h1F;
      up_mode    = 1'b0;
      load       = 1'b1;
      start_stop = 1'b1;
      step();
      load       = 1'b0;
      start_stop = 1'b0;
      checks++;
      if (count_bcd !== 8'h19 || running !== 1'b0 || expired !== 1'b0) begin
         errors++;
         $display("FAIL clamp_prio: cnt=%h run=%b exp=%b expected 19 0 0",
                  count_bcd, running, expired);
      end
      do_load(8'h00, 1'b0);
      pulse_ss();
      checks++;
      if (done !== 1'b1 || expired !== 1'b1 || running !== 1'b0 || count_bcd !== 8'h00) begin
         errors++;
         $display("FAIL start_terminal: done=%b exp=%b run=%b cnt=%h expected 1 1 0 00",
                  done, expired, running, count_bcd);
      end
   endtask

   task automatic test_blank_reset();
      do_load(8'h30, 1'b0);
      pulse_ss();
      blank = 1'b1;
      sb.push_back('{8'h29, 4});
      sb.push_back('{8'h28, 4});
      drain("blank_step");
      checks++;
      if (seg !== SEG_OFF) begin
         errors++;
         $display("FAIL blank_seg: seg=%b expected %b", seg, SEG_OFF);
      end
      step();
      blank = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (count_bcd !== 8'h00 || running !== 1'b0 || seg !== SEG_00) begin
         errors++;
         $display("FAIL async_reset: cnt=%h run=%b seg=%b expected 00 0 %b",
                  count_bcd, running, seg, SEG_00);
      end
      #1 reset = 1'b0;
      step();
      do_load(8'h02, 1'b0);
      pulse_ss();
      sb.push_back('{8'h01, 4});
      drain("after_reset_step");
   endtask

   initial begin
      reset      = 1'b1;
      load       = 1'b0;
      load_value = 8'h00;
      up_mode    = 1'b0;
      start_stop = 1'b0;
      blank      = 1'b0;
      test_reset();
      test_down();
      test_borrow();
      test_pause();
      test_up();
      test_clamp_priority();
      test_blank_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
